// File: rtl/gcc_pkg.sv
// Shared types and constants for the GCC point-stream feeder.
package gcc_pkg;

    localparam int COORD_W  = 8;
    localparam int WEIGHT_W = 4;
    localparam int CAP_LAT  = 2;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    typedef struct packed {
        logic [COORD_W-1:0]  x;
        logic [COORD_W-1:0]  y;
        logic [WEIGHT_W-1:0] w;
    } point_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } result_t;

endpackage

// File: rtl/gcc_res_fifo.sv
// Synchronous result FIFO with full/empty flags; push while full is accepted only alongside a pop.
module gcc_res_fifo #(
    parameter int RES_DEPTH = 8,
    parameter int WIDTH     = 16
) (
    input  logic             CLK,
    input  logic             RESET_,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(RES_DEPTH);

    logic [WIDTH-1:0] mem [RES_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_) begin
        if (!RESET_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage arrays carry no reset; the pointers alone define which entries are valid.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/gcc_stream_feeder.sv
// Streams a loaded point list into the GCC core and buffers the returned centroids.
// Define GCC_FEED_LAST_ONLY_EN to keep only the centroid of the final point of each run.
module gcc_stream_feeder
    import gcc_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int RES_DEPTH = 8
) (
    input  logic                        CLK,
    input  logic                        RESET_,
    input  logic                        LOAD_,
    input  logic [$clog2(DEPTH)-1:0]    LADDR,
    input  logic [COORD_W-1:0]          LX,
    input  logic [COORD_W-1:0]          LY,
    input  logic [WEIGHT_W-1:0]         LW,
    input  logic                        START,
    input  logic [$clog2(DEPTH):0]      COUNT,
    output logic                        GRST_,
    output logic [COORD_W-1:0]          Xi,
    output logic [COORD_W-1:0]          Yi,
    output logic [WEIGHT_W-1:0]         Wi,
    input  logic                        READY_,
    input  logic [COORD_W-1:0]          Xc,
    input  logic [COORD_W-1:0]          Yc,
    output logic [COORD_W-1:0]          RX,
    output logic [COORD_W-1:0]          RY,
    output logic                        RVALID,
    input  logic                        RPOP,
    output logic                        BUSY,
    output logic                        DONE,
    output logic                        ERR,
    output logic                        OVF
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    point_t               mem [DEPTH];
    state_t               state;
    logic [AW-1:0]        idx;
    logic [AW-1:0]        idx_next;
    logic [CW-1:0]        n;
    logic                 drain_cnt;
    point_t               pt;
    logic                 grst;
    logic                 done;
    logic                 err;
    logic                 ovf;
    logic [CAP_LAT-1:0]   tag;
    logic                 is_last;
    logic                 start_ok;
    logic                 cap;
    logic                 push_req;
    logic                 fifo_full;
    logic                 fifo_empty;
    result_t              head;

    assign idx_next = idx + AW'(1);
    assign is_last  = ({1'b0, idx} == n - CW'(1));
    assign start_ok = START && (COUNT != '0) && (COUNT <= CW'(DEPTH));

    // The tag marks the edge at which the core's centroid for a streamed point is valid.
`ifdef GCC_FEED_LAST_ONLY_EN
    logic [CAP_LAT-1:0] tag_last;

    always_ff @(posedge CLK or negedge RESET_) begin
        if (!RESET_) tag_last <= '0;
        else         tag_last <= {tag_last[CAP_LAT-2:0], (state == STREAM) && is_last};
    end

    assign cap = tag[CAP_LAT-1] && tag_last[CAP_LAT-1];
`else
    assign cap = tag[CAP_LAT-1];
`endif

    assign push_req = cap && !READY_;

    always_ff @(posedge CLK) begin
        if (state == IDLE && !LOAD_) mem[LADDR] <= '{x: LX, y: LY, w: LW};
    end

    always_ff @(posedge CLK or negedge RESET_) begin
        if (!RESET_) begin
            state     <= IDLE;
            idx       <= '0;
            n         <= '0;
            drain_cnt <= 1'b0;
            pt        <= '0;
            grst      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            tag       <= '0;
        end else begin
            done <= 1'b0;
            tag  <= {tag[CAP_LAT-2:0], state == STREAM};
            if (cap && READY_)                       err <= 1'b1;
            if (push_req && fifo_full && !RPOP)      ovf <= 1'b1;
            case (state)
                IDLE: begin
                    grst      <= 1'b0;
                    pt        <= '0;
                    idx       <= '0;
                    drain_cnt <= 1'b0;
                    if (start_ok) begin
                        state <= STREAM;
                        n     <= COUNT;
                        err   <= 1'b0;
                        ovf   <= 1'b0;
                        grst  <= 1'b1;
                        pt    <= mem[0];
                    end
                end
                STREAM: begin
                    if (is_last) begin
                        state <= DRAIN;
                    end else begin
                        idx <= idx_next;
                        pt  <= mem[idx_next];
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        grst  <= 1'b0;
                        pt    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    gcc_res_fifo #(
        .RES_DEPTH (RES_DEPTH),
        .WIDTH     ($bits(result_t))
    ) u_res_fifo (
        .CLK    (CLK),
        .RESET_ (RESET_),
        .push   (push_req),
        .wdata  ({Xc, Yc}),
        .pop    (RPOP),
        .rdata  (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign GRST_  = grst;
    assign Xi     = pt.x;
    assign Yi     = pt.y;
    assign Wi     = pt.w;
    assign RX     = head.x;
    assign RY     = head.y;
    assign RVALID = !fifo_empty;
    assign BUSY   = (state != IDLE);
    assign DONE   = done;
    assign ERR    = err;
    assign OVF    = ovf;

endmodule

// File: doc/gcc_stream_feeder.md
# gcc_stream_feeder

Source side of the GCC point-stream interface. It holds a loadable list of weighted points and, on START, releases the GCC core from reset. It then streams one point per clock on Xi/Yi/Wi and aligns each returned Xc/Yc centroid to the point that produced it. Captured centroids are buffered in a small result FIFO for a host or bench to pop. Between runs it holds the GCC core in reset, so the core never absorbs idle data.

## Interface
- DEPTH, 16: point-memory entries; also the maximum COUNT.
- RES_DEPTH, 8: result FIFO entries, power of two.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_  in  1  asynchronous, active-low reset.
- LOAD_  in  1  active-low point write strobe; honoured only in IDLE.
- LADDR  in  4  point-memory write address.
- LX, LY  in  8  point coordinates to write.
- LW  in  4  point weight to write.
- START  in  1  run request; sampled only in IDLE.
- COUNT  in  5  number of points to send, 1..DEPTH; sampled with START.
- GRST_  out  1  drives the GCC core's RESET_.
- Xi, Yi  out  8  point coordinates to the core.
- Wi  out  4  point weight to the core.
- READY_  in  1  core ready, active-low.
- Xc, Yc  in  8  core centroid.
- RX, RY  out  8  result FIFO head.
- RVALID  out  1  result FIFO not empty.
- RPOP  in  1  pop the FIFO head; ignored when empty.
- BUSY  out  1  high in STREAM and DRAIN.
- DONE  out  1  one-cycle pulse on the DRAIN→IDLE transition.
- ERR  out  1  sticky flag: a capture was attempted while READY_=1.
- OVF  out  1  sticky flag: a capture was attempted while the FIFO was full.

## Operation
- States: IDLE, STREAM, DRAIN.
- IDLE:
  - GRST_=0; Xi/Yi/Wi=0.
  - LOAD_=0 writes {LX,LY,LW} to mem[LADDR].
  - START=1 with 1≤COUNT≤DEPTH latches N=COUNT, clears ERR/OVF, and moves to STREAM.
  - START with COUNT=0 or COUNT>DEPTH is ignored.
- STREAM:
  - GRST_=1; Xi/Yi/Wi=mem[idx]; idx advances 0..N-1, one per cycle.
  - After idx=N-1 is driven, moves to DRAIN.
- DRAIN:
  - GRST_=1; Xi/Yi/Wi hold the last point.
  - Lasts 2 cycles, then IDLE with the DONE pulse.
- Capture:
  - A 2-stage tag pipeline marks the edge E_i+2, where E_i is the edge at which point i is sampled.
  - At each tagged edge, {Xc,Yc} is pushed to the FIFO if READY_=0.
  - If READY_=1 at a tagged edge: set ERR and push nothing.
  - If the FIFO is full at a tagged edge: set OVF and drop the value.
- FIFO:
  - Push and RPOP in the same cycle while full: both happen; no OVF.
  - Push and RPOP while empty: push only.
- START, LOAD_ and COUNT are ignored while BUSY.
- RESET_ low at any time, including mid-run:
  - State returns to IDLE with idx=0 and the tag pipeline cleared.
  - The FIFO is emptied and ERR/OVF are cleared.
  - Point memory is not reset.

## Timing
- Reset values: GRST_=0; Xi=Yi=0; Wi=0; RX=RY=0; RVALID=0; BUSY=0; DONE=0; ERR=0; OVF=0.
- Edge S samples START. After S: BUSY=1, GRST_=1, and point 0 is on Xi.
- E_0 = S+1, E_i = S+1+i.
- The core's READY_ goes low after E_1, so the first capture at E_0+2 must see READY_=0.
- Captures happen at edges S+3 .. S+N+2. RVALID rises after S+3 if the FIFO was empty.
- The last capture edge, S+N+2, is also the DRAIN→IDLE transition: BUSY falls and DONE pulses for one cycle. The next START is accepted one cycle later.
- RX/RY show the FIFO head combinationally. RPOP takes effect at the edge.

## Configuration
- GCC_FEED_LAST_ONLY_EN:
  - Defined: only the tagged edge for point N-1 pushes, giving one result per run. ERR is checked only at that edge.
  - Undefined: every point produces a capture, giving N results per run.

## Structure
- Package gcc_pkg holds:
  - The state enum {IDLE, STREAM, DRAIN}.
  - Width constants: coordinate width 8, weight width 4.
  - CAP_LAT=2.
- Sub-module gcc_res_fifo: synchronous FIFO, RES_DEPTH×16 bits, with full/empty flags and simultaneous push/pop.

## Test plan
- Load (10,20,W1), COUNT=1, START → one result (10,20); DONE at S+3; ERR=OVF=0.
- Load (10,20,1) and (30,40,1), COUNT=2 → results (10,20) then (20,30).
- Load (0,0,3) and (100,100,1), COUNT=2 → results (0,0) then (25,25).
- COUNT=12 with RES_DEPTH=8 and no RPOP → 8 results kept, OVF=1. Repeat with RPOP held high → 12 results, OVF=0.
- Assert RESET_ low mid-STREAM at idx=3 → immediate IDLE, GRST_=0, RVALID=0. A following run with COUNT=2 gives results matching the 2-point case above.
- START with COUNT=0, and LOAD_ while BUSY → no state change; memory contents unchanged.
